// File: rtl/game_sequencer.sv
// game_sequencer: frame-synchronous controller for the car-dodging game.
// Runs the IDLE/PLAY/CRASH/OVER machine and turns VGA frame pulses into
// obstacle and player step pulses. It also tracks score, lives and level.
// Every output comes straight from a register.
`timescale 1ns/1ps

module game_sequencer #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned BASE_DIV     = 8,
  parameter int unsigned LEVEL_STEP   = 10,
  parameter int unsigned MAX_LEVEL    = 7,
  parameter int unsigned CRASH_FRAMES = 60
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iStart,
  input  logic       iFrame,
  input  logic       iChoque,
  input  logic       iPunto,
  output logic       oEnableLFSR,
  output logic       oPasoObstaculo,
  output logic       oPasoJugador,
  output logic       oPintar,
  output logic       oResetPintar,
  output logic [8:0] oPuntos,
  output logic [1:0] oVidas,
  output logic [2:0] oNivel,
  output logic [1:0] oEstado
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CRASH = 2'd2,
    OVER  = 2'd3
  } state_e;

  localparam logic [1:0] LivesInit  = 2'(LIVES);
  localparam logic [4:0] BaseDiv    = 5'(BASE_DIV);
  localparam logic [5:0] LevelStep  = 6'(LEVEL_STEP);
  localparam logic [2:0] MaxLevel   = 3'(MAX_LEVEL);
  localparam logic [7:0] CrashLimit = 8'(CRASH_FRAMES);

  state_e     state_q, state_d;
  logic       startMeta_q, startSync_q, startPrev_q, framePrev_q;
  logic       startEdge, frameEdge;
  logic [3:0] frameCnt_q, frameCnt_d;
  logic [5:0] levelCnt_q, levelCnt_d;
  logic [7:0] crashCnt_q, crashCnt_d;
  logic [8:0] puntos_q, puntos_d;
  logic [1:0] vidas_q, vidas_d;
  logic [2:0] nivel_q, nivel_d;
  logic       pasoJug_q, pasoJug_d;
  logic       pasoObs_q, pasoObs_d;
  logic       resetPintar_q, resetPintar_d;
  logic       pintar_q, pintar_d;
  logic       enableLfsr_q, enableLfsr_d;
  logic [4:0] divisor;
  logic       stepDue;
  logic [7:0] crashNext;
  logic       crashDone;
  logic [5:0] levelNext;

  // The start button is asynchronous, so it passes through two flops before
  // edge detection. iFrame is already synchronous and only needs its previous value.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      startMeta_q <= 1'b0;
      startSync_q <= 1'b0;
      startPrev_q <= 1'b0;
      framePrev_q <= 1'b0;
    end else begin
      startMeta_q <= iStart;
      startSync_q <= startMeta_q;
      startPrev_q <= startSync_q;
      framePrev_q <= iFrame;
    end
  end

  assign startEdge = startSync_q & ~startPrev_q;
  assign frameEdge = iFrame & ~framePrev_q;

  // Frames per obstacle step shrink as the level rises. The value never goes below 1.
  assign divisor   = (({2'b00, nivel_q} + 5'd1) >= BaseDiv) ? 5'd1
                                                            : (BaseDiv - {2'b00, nivel_q});
  assign stepDue   = ({1'b0, frameCnt_q} >= (divisor - 5'd1));
  assign crashNext = crashCnt_q + 8'd1;
  assign crashDone = frameEdge && (crashNext == CrashLimit);
  assign levelNext = levelCnt_q + 6'd1;

  // State register for the game machine.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A collision on the last life ends the game.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startEdge) state_d = PLAY;
      PLAY:    if (iChoque) state_d = (vidas_q == 2'd1) ? OVER : CRASH;
      CRASH:   if (crashDone) state_d = PLAY;
      OVER:    if (startEdge) state_d = PLAY;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values. A collision takes precedence over a point in the same cycle.
  always_comb begin
    puntos_d      = puntos_q;
    vidas_d       = vidas_q;
    nivel_d       = nivel_q;
    frameCnt_d    = frameCnt_q;
    levelCnt_d    = levelCnt_q;
    crashCnt_d    = crashCnt_q;
    pasoJug_d     = 1'b0;
    pasoObs_d     = 1'b0;
    resetPintar_d = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (startEdge) begin
          puntos_d      = '0;
          vidas_d       = LivesInit;
          nivel_d       = '0;
          frameCnt_d    = '0;
          levelCnt_d    = '0;
          crashCnt_d    = '0;
          resetPintar_d = 1'b1;
        end
      end
      PLAY: begin
        if (iChoque) begin
          vidas_d    = vidas_q - 2'd1;
          crashCnt_d = '0;
        end else begin
          if (frameEdge) begin
            pasoJug_d = 1'b1;
            if (stepDue) begin
              pasoObs_d  = 1'b1;
              frameCnt_d = '0;
            end else begin
              frameCnt_d = frameCnt_q + 4'd1;
            end
          end
          if (iPunto) begin
            if (puntos_q != 9'd511) puntos_d = puntos_q + 9'd1;
            if (levelNext == LevelStep) begin
              levelCnt_d = '0;
              if (nivel_q < MaxLevel) nivel_d = nivel_q + 3'd1;
            end else begin
              levelCnt_d = levelNext;
            end
          end
        end
      end
      CRASH: begin
        if (frameEdge) begin
          crashCnt_d = crashNext;
          if (crashDone) begin
            resetPintar_d = 1'b1;
            frameCnt_d    = '0;
          end
        end
      end
      default: ;
    endcase
    enableLfsr_d = (state_d == PLAY);
    case (state_d)
      PLAY, OVER: pintar_d = 1'b1;
      CRASH:      pintar_d = ~crashCnt_d[3];
      default:    pintar_d = 1'b0;
    endcase
  end

  // Register the datapath and the outputs. Reset clears any pending pulse.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      puntos_q      <= '0;
      vidas_q       <= LivesInit;
      nivel_q       <= '0;
      frameCnt_q    <= '0;
      levelCnt_q    <= '0;
      crashCnt_q    <= '0;
      pasoJug_q     <= 1'b0;
      pasoObs_q     <= 1'b0;
      resetPintar_q <= 1'b0;
      pintar_q      <= 1'b0;
      enableLfsr_q  <= 1'b0;
    end else begin
      puntos_q      <= puntos_d;
      vidas_q       <= vidas_d;
      nivel_q       <= nivel_d;
      frameCnt_q    <= frameCnt_d;
      levelCnt_q    <= levelCnt_d;
      crashCnt_q    <= crashCnt_d;
      pasoJug_q     <= pasoJug_d;
      pasoObs_q     <= pasoObs_d;
      resetPintar_q <= resetPintar_d;
      pintar_q      <= pintar_d;
      enableLfsr_q  <= enableLfsr_d;
    end
  end

  assign oEnableLFSR    = enableLfsr_q;
  assign oPasoObstaculo = pasoObs_q;
  assign oPasoJugador   = pasoJug_q;
  assign oPintar        = pintar_q;
  assign oResetPintar   = resetPintar_q;
  assign oPuntos        = puntos_q;
  assign oVidas         = vidas_q;
  assign oNivel         = nivel_q;
  assign oEstado        = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: scoreboard bench for game_sequencer.
// Each stimulus pushes its expected pulses, tagged with the expected cycle, into a queue.
// A negedge monitor pops and compares each pulse when it appears.
// A small game model tracks the expected state, score, lives and level.
`timescale 1ns/1ps

module tb_game_sequencer;

  localparam int LIVES        = 3;
  localparam int BASE_DIV     = 8;
  localparam int LEVEL_STEP   = 10;
  localparam int MAX_LEVEL    = 7;
  localparam int CRASH_FRAMES = 60;

  localparam int S_IDLE  = 0;
  localparam int S_PLAY  = 1;
  localparam int S_CRASH = 2;
  localparam int S_OVER  = 3;

  logic       iClk    = 1'b0;
  logic       iReset  = 1'b1;
  logic       iStart  = 1'b0;
  logic       iFrame  = 1'b0;
  logic       iChoque = 1'b0;
  logic       iPunto  = 1'b0;
  logic       oEnableLFSR, oPasoObstaculo, oPasoJugador, oPintar, oResetPintar;
  logic [8:0] oPuntos;
  logic [1:0] oVidas;
  logic [2:0] oNivel;
  logic [1:0] oEstado;

  game_sequencer #(
    .LIVES(LIVES), .BASE_DIV(BASE_DIV), .LEVEL_STEP(LEVEL_STEP),
    .MAX_LEVEL(MAX_LEVEL), .CRASH_FRAMES(CRASH_FRAMES)
  ) dut (
    .iClk(iClk), .iReset(iReset), .iStart(iStart), .iFrame(iFrame),
    .iChoque(iChoque), .iPunto(iPunto), .oEnableLFSR(oEnableLFSR),
    .oPasoObstaculo(oPasoObstaculo), .oPasoJugador(oPasoJugador),
    .oPintar(oPintar), .oResetPintar(oResetPintar), .oPuntos(oPuntos),
    .oVidas(oVidas), .oNivel(oNivel), .oEstado(oEstado)
  );

  // 25 MHz pixel clock
  always #20 iClk = ~iClk;

  typedef struct {
    bit jug;
    bit obs;
    bit rp;
    int cyc;
  } pulse_t;

  pulse_t expQ[$];
  pulse_t monE;

  int cyc        = 0;
  int checkCount = 0;
  int errorCount = 0;
  int jugCount   = 0;
  int obsCount   = 0;
  int rpCount    = 0;
  int j0, o0, r0;

  int mState, mPuntos, mVidas, mNivel, mFrameCnt, mLevelCnt, mCrashCnt;

  // Cycle index, used to check when each pulse arrives
  always @(posedge iClk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic pushPulse(input bit jug, input bit obs, input bit rp, input int when);
    pulse_t p;
    p.jug = jug;
    p.obs = obs;
    p.rp  = rp;
    p.cyc = when;
    expQ.push_back(p);
  endtask

  // Every pulse seen on the DUT must match the next queued expectation
  always @(negedge iClk) begin
    if (!iReset && (oPasoJugador || oPasoObstaculo || oResetPintar)) begin
      if (oPasoJugador)   jugCount++;
      if (oPasoObstaculo) obsCount++;
      if (oResetPintar)   rpCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedPulse", 1, 0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("pulseCycle", cyc, monE.cyc);
        checkOutput("pasoJugador", int'(oPasoJugador), int'(monE.jug));
        checkOutput("pasoObstaculo", int'(oPasoObstaculo), int'(monE.obs));
        checkOutput("resetPintar", int'(oResetPintar), int'(monE.rp));
      end
    end
  end

  function automatic int expPintar();
    if (mState == S_PLAY || mState == S_OVER) return 1;
    if (mState == S_CRASH) return (((mCrashCnt / 8) % 2) == 0) ? 1 : 0;
    return 0;
  endfunction

  task automatic checkState(input string tag);
    checkOutput({tag, ".estado"}, int'(oEstado), mState);
    checkOutput({tag, ".puntos"}, int'(oPuntos), mPuntos);
    checkOutput({tag, ".vidas"}, int'(oVidas), mVidas);
    checkOutput({tag, ".nivel"}, int'(oNivel), mNivel);
    checkOutput({tag, ".pintar"}, int'(oPintar), expPintar());
    checkOutput({tag, ".lfsr"}, int'(oEnableLFSR), (mState == S_PLAY) ? 1 : 0);
  endtask

  task automatic newGameModel();
    mState    = S_PLAY;
    mPuntos   = 0;
    mVidas    = LIVES;
    mNivel    = 0;
    mFrameCnt = 0;
    mLevelCnt = 0;
    mCrashCnt = 0;
  endtask

  // Advance the game model for one sampled input cycle and queue any pulses it implies
  task automatic modelEvent(input bit frame, input bit punto, input bit choque);
    int div;
    bit obs;
    if (mState == S_PLAY) begin
      if (choque) begin
        mVidas--;
        mCrashCnt = 0;
        mState = (mVidas == 0) ? S_OVER : S_CRASH;
      end else begin
        if (frame) begin
          div = BASE_DIV - mNivel;
          if (div < 1) div = 1;
          obs = (mFrameCnt >= div - 1);
          mFrameCnt = obs ? 0 : mFrameCnt + 1;
          pushPulse(1'b1, obs, 1'b0, cyc + 1);
        end
        if (punto) begin
          if (mPuntos < 511) mPuntos++;
          mLevelCnt++;
          if (mLevelCnt == LEVEL_STEP) begin
            mLevelCnt = 0;
            if (mNivel < MAX_LEVEL) mNivel++;
          end
        end
      end
    end else if (mState == S_CRASH && frame) begin
      mCrashCnt++;
      if (mCrashCnt == CRASH_FRAMES) begin
        pushPulse(1'b0, 1'b0, 1'b1, cyc + 1);
        mState    = S_PLAY;
        mFrameCnt = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, then one quiet cycle so that the next frame is a fresh edge
  task automatic applyStimulus(input bit frame, input bit punto, input bit choque);
    iFrame  = frame;
    iPunto  = punto;
    iChoque = choque;
    modelEvent(frame, punto, choque);
    @(posedge iClk); #1;
    iFrame  = 1'b0;
    iPunto  = 1'b0;
    iChoque = 1'b0;
    @(posedge iClk); #1;
    checkState("stim");
  endtask

  task automatic holdFrame(input int n);
    iFrame = 1'b1;
    modelEvent(1'b1, 1'b0, 1'b0);
    repeat (n) begin @(posedge iClk); #1; end
    iFrame = 1'b0;
    @(posedge iClk); #1;
    checkState("holdFrame");
  endtask

  task automatic pressStart();
    iStart = 1'b1;
    if (mState == S_IDLE || mState == S_OVER) begin
      pushPulse(1'b0, 1'b0, 1'b1, cyc + 3);
      newGameModel();
    end
    repeat (4) begin @(posedge iClk); #1; end
    iStart = 1'b0;
    repeat (4) begin @(posedge iClk); #1; end
    checkState("start");
  endtask

  task automatic applyReset(input string tag);
    iReset = 1'b1;
    #2;
    checkOutput({tag, ".estado"}, int'(oEstado), 0);
    checkOutput({tag, ".puntos"}, int'(oPuntos), 0);
    checkOutput({tag, ".vidas"}, int'(oVidas), LIVES);
    checkOutput({tag, ".nivel"}, int'(oNivel), 0);
    checkOutput({tag, ".pintar"}, int'(oPintar), 0);
    checkOutput({tag, ".lfsr"}, int'(oEnableLFSR), 0);
    checkOutput({tag, ".pasoJug"}, int'(oPasoJugador), 0);
    checkOutput({tag, ".pasoObs"}, int'(oPasoObstaculo), 0);
    checkOutput({tag, ".resetPintar"}, int'(oResetPintar), 0);
    expQ.delete();
    newGameModel();
    mState = S_IDLE;
    @(posedge iClk); #1;
    iReset = 1'b0;
    @(posedge iClk); #1;
  endtask

  // Guard against a hung run
  initial begin
    #2400000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checkCount, errorCount);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    @(posedge iClk); #1;
    applyReset("por");
    checkState("idle");

    // First game: 24 frames with no hits
    j0 = jugCount; o0 = obsCount; r0 = rpCount;
    pressStart();
    for (int i = 0; i < 24; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("jugCount24", jugCount - j0, 24);
    checkOutput("obsCount24", obsCount - o0, 3);
    checkOutput("rpCountStart", rpCount - r0, 1);

    // Collision and point in the same cycle at score 5
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("comboPuntos", int'(oPuntos), 5);
    checkOutput("comboVidas", int'(oVidas), 2);
    checkOutput("comboEstado", int'(oEstado), S_CRASH);

    // Crash freeze with blinking paint, then respawn
    r0 = rpCount;
    for (int i = 0; i < CRASH_FRAMES; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("crashRespawn", rpCount - r0, 1);
    checkOutput("crashScoreKept", int'(oPuntos), 5);
    checkOutput("crashBackToPlay", int'(oEstado), S_PLAY);

    // Level 1 gives a divisor of 7
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("nivel1", int'(oNivel), 1);
    o0 = obsCount;
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("obsLevel1", obsCount - o0, 2);

    // Level 7 gives a step on every frame, and the level stays capped at 7
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("nivel7", int'(oNivel), 7);
    checkOutput("puntos70", int'(oPuntos), 70);
    o0 = obsCount;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("obsLevel7", obsCount - o0, 5);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("nivelCap", int'(oNivel), 7);

    // A start press during PLAY is ignored
    pressStart();

    // Second crash; hits and points are ignored while crashed
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("crash2Vidas", int'(oVidas), 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < CRASH_FRAMES; i++) applyStimulus(1'b1, 1'b0, 1'b0);

    // Third crash ends the game; no pulses while in OVER
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("overEstado", int'(oEstado), S_OVER);
    checkOutput("overVidas", int'(oVidas), 0);
    j0 = jugCount; o0 = obsCount; r0 = rpCount;
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("overNoJug", jugCount - j0, 0);
    checkOutput("overNoObs", obsCount - o0, 0);
    checkOutput("overNoRp", rpCount - r0, 0);

    // Restart from OVER
    pressStart();
    checkOutput("restartPuntos", int'(oPuntos), 0);
    checkOutput("restartVidas", int'(oVidas), 3);
    checkOutput("restartNivel", int'(oNivel), 0);

    // Score saturates at 511
    for (int i = 0; i < 512; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("puntosSat", int'(oPuntos), 511);

    // A held frame produces only one pulse
    holdFrame(5);

    // Reset in the middle of a crash
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyReset("midCrash");
    checkState("afterReset");

    // A frame arriving together with reset must not produce a pulse
    pressStart();
    iFrame = 1'b1;
    applyReset("pending");
    iFrame = 1'b0;
    repeat (3) begin @(posedge iClk); #1; end
    checkState("final");
    checkOutput("queueEmpty", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
